pc_sequencer: RTL

Fetch/commit sequencer for the single-cycle MIPS datapath. Owns the program counter and drives instruction-memory fetch over a valid handshake. Holds the fetched word stable for control/aluControl/ALU, then issues a one-cycle commit strobe and selects the next PC (sequential, branch or jump). Replaces the free-running test PC with a controlled start/stall/halt machine.

---
 rtl/mips_seq_pkg.sv | 13 +
 rtl/next_pc_calc.sv | 31 +++
 rtl/pc_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/mips_seq_pkg.sv
// Shared types and constants for the MIPS fetch/commit sequencer.
// Holds the state encoding, the default halt encoding and instruction field widths.
package mips_seq_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} seqState_t;

   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
   localparam logic [31:0] PC_STEP       = 32'd4;
   localparam int          JUMP_IDX_W    = 26;
   localparam int          BR_IMM_W      = 16;
   localparam int          PC_SEG_W      = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential pc+4.
// Jump wins over branch; all arithmetic wraps modulo 2^32.
module next_pc_calc
   import mips_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instruction,
   input  logic        jumpEnable,
   input  logic        branchEnable,
   input  logic        isZero,
   output logic [31:0] nextPc
);

   logic [31:0] pcPlus4;
   logic [31:0] brOffset;
   logic [31:0] jumpTarget;

   assign pcPlus4    = pc + PC_STEP;
   assign brOffset   = {{(32-BR_IMM_W-2){instruction[BR_IMM_W-1]}}, instruction[BR_IMM_W-1:0], 2'b00};
   // Jump keeps the 256MB segment of the sequential PC.
   assign jumpTarget = {pcPlus4[31 -: PC_SEG_W], instruction[JUMP_IDX_W-1:0], 2'b00};

   always_comb begin
      nextPc = pcPlus4;
      if (jumpEnable)
         nextPc = jumpTarget;
      else if (branchEnable && isZero)
         nextPc = pcPlus4 + brOffset;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/commit sequencer: owns the PC, handshakes instruction fetch, strobes commit.
// Optional retired-instruction counter enabled by PC_SEQ_RETIRE_COUNT_EN.
module pc_sequencer
   import mips_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD    = HALT_WORD_DEF
)
(
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   output logic        fetchReq,
   output logic [31:0] fetchAddr,
   input  logic        fetchValid,
   input  logic [31:0] fetchData,
   output logic [31:0] currentInstruction,
   input  logic        jumpEnable,
   input  logic        branchEnable,
   input  logic        isZero,
   input  logic        stall,
   output logic        commit,
   output logic [31:0] pc,
   output logic        halted,
   output logic [31:0] retiredCount
);

   seqState_t   state, stateNext;
   logic        loadVector;
   logic        capture;
   logic [31:0] nextPc;

   next_pc_calc uNextPc (
      .pc          (pc),
      .instruction (currentInstruction),
      .jumpEnable  (jumpEnable),
      .branchEnable(branchEnable),
      .isZero      (isZero),
      .nextPc      (nextPc)
   );

   always_comb begin
      stateNext  = state;
      fetchReq   = 1'b0;
      commit     = 1'b0;
      halted     = 1'b0;
      loadVector = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: if (start) begin
            loadVector = 1'b1;
            stateNext  = FETCH;
         end
         FETCH: begin
            fetchReq = 1'b1;
            if (fetchValid) begin
               capture   = 1'b1;
               stateNext = EXEC;
            end
         end
         EXEC: begin
            // Halt encoding never commits and leaves pc on the halt word.
            if (currentInstruction == HALT_WORD)
               stateNext = HALT;
            else if (!stall) begin
               commit    = 1'b1;
               stateNext = FETCH;
            end
         end
         HALT: begin
            halted = 1'b1;
            if (start) begin
               loadVector = 1'b1;
               stateNext  = FETCH;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state              <= IDLE;
         pc                 <= RESET_VECTOR;
         currentInstruction <= '0;
      end else begin
         state <= stateNext;
         if (loadVector)
            pc <= RESET_VECTOR;
         else if (commit)
            pc <= nextPc;
         if (capture)
            currentInstruction <= fetchData;
      end
   end

   assign fetchAddr = pc;

`ifdef PC_SEQ_RETIRE_COUNT_EN
   logic [31:0] retireCnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         retireCnt <= '0;
      else if (loadVector)
         retireCnt <= '0;
      else if (commit && (retireCnt != 32'hFFFF_FFFF))
         retireCnt <= retireCnt + 32'd1;
   end

   assign retiredCount = retireCnt;
`else
   assign retiredCount = '0;
`endif

endmodule
